// File: rtl/bus_tx_scheduler.sv
// bus_tx_scheduler
// Round-robin transmit scheduler for 32 CAN bus channels. One transfer runs at a
// time: IDLE arbitrates, START pulses start_out, WAIT waits for done_in (or aborts
// after TIMEOUT cycles), and RELEASE drops the grant and records the winner for the
// next round-robin search. All outputs are registered.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   enable       scheduler enable; no new grant while low
//   req_bus      per-bus pending-transmit request (level)
//   done_in      completion strobe from the granted channel
//   sel_bus      registered index of the granted bus (holds after release)
//   grant        registered one-hot grant, 1 << sel_bus during a transfer
//   start_out    one-cycle launch pulse (START state)
//   active       high in START, WAIT and RELEASE
//   timeout_err  one-cycle abort flag, high in the RELEASE cycle after a timeout
module bus_tx_scheduler #(
  parameter int unsigned N_BUS   = 32,
  parameter logic [15:0] TIMEOUT = 16'd1000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [N_BUS-1:0]         req_bus,
  input  logic                     done_in,
  output logic [$clog2(N_BUS)-1:0] sel_bus,
  output logic [N_BUS-1:0]         grant,
  output logic                     start_out,
  output logic                     active,
  output logic                     timeout_err
);

  localparam int unsigned SelW = $clog2(N_BUS);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] START   = 2'd1;
  localparam logic [1:0] WAIT    = 2'd2;
  localparam logic [1:0] RELEASE = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [SelW-1:0] sel_q, sel_d;
  logic [N_BUS-1:0] grant_q, grant_d;
  logic            start_q, start_d;
  logic            active_q, active_d;
  logic            tmo_q, tmo_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [SelW-1:0] last_q, last_d;

  logic [SelW-1:0] pick;

  // Search last_ptr+1, last_ptr+2, ... with natural 5-bit wrap; i = N_BUS lands on
  // last_ptr itself, giving it the lowest priority.
  always_comb begin
    logic            found;
    logic [SelW-1:0] idx;
    pick  = last_q;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= int'(N_BUS); i++) begin
      idx = last_q + SelW'(i);
      if (!found && req_bus[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    grant_d  = grant_q;
    start_d  = 1'b0;
    active_d = active_q;
    tmo_d    = 1'b0;
    cnt_d    = cnt_q;
    last_d   = last_q;
    unique case (state_q)
      IDLE: begin
        if (enable && (|req_bus)) begin
          state_d       = START;
          sel_d         = pick;
          grant_d       = '0;
          grant_d[pick] = 1'b1;
          start_d       = 1'b1;
          active_d      = 1'b1;
        end
      end
      START: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        // done_in takes precedence over the timeout in the same cycle
        if (done_in) begin
          state_d = RELEASE;
        end else if (cnt_q == (TIMEOUT - 16'd1)) begin
          state_d = RELEASE;
          tmo_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RELEASE: begin
        state_d  = IDLE;
        grant_d  = '0;
        last_d   = sel_q;
        active_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      grant_q  <= '0;
      start_q  <= 1'b0;
      active_q <= 1'b0;
      tmo_q    <= 1'b0;
      cnt_q    <= '0;
      last_q   <= SelW'(N_BUS - 1);
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      grant_q  <= grant_d;
      start_q  <= start_d;
      active_q <= active_d;
      tmo_q    <= tmo_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
    end
  end

  assign sel_bus     = sel_q;
  assign grant       = grant_q;
  assign start_out   = start_q;
  assign active      = active_q;
  assign timeout_err = tmo_q;

endmodule

// File: tb/tb_bus_tx_scheduler.sv
// Directed bench for bus_tx_scheduler (built with TIMEOUT = 8).
module tb_bus_tx_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] req_bus = '0;
  logic        done_in = 1'b0;
  logic [4:0]  sel_bus;
  logic [31:0] grant;
  logic        start_out;
  logic        active;
  logic        timeout_err;

  int tests = 0;
  int fails = 0;

  bus_tx_scheduler #(
    .N_BUS  (32),
    .TIMEOUT(16'd8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .req_bus    (req_bus),
    .done_in    (done_in),
    .sel_bus    (sel_bus),
    .grant      (grant),
    .start_out  (start_out),
    .active     (active),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One transfer record: done_at is the WAIT-cycle index (0-based) where done_in is
  // raised (99 = never); exp_active counts cycles with active high.
  typedef struct {
    logic [31:0] req;
    int          done_at;
    logic [4:0]  exp_sel;
    logic        exp_tmo;
    int          exp_active;
  } vec_t;

  vec_t vecs[10];

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    enable = 1'b0;
    req_bus = '0;
    done_in = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_vec(input int n, input vec_t v);
    int          waits;
    int          act_cnt;
    logic [31:0] exp_g;
    string       tag;
    tag     = $sformatf("v%0d", n);
    exp_g   = 32'd1 << v.exp_sel;
    waits   = v.exp_active - 2;
    act_cnt = 0;
    // In IDLE: present request
    req_bus = v.req;
    enable  = 1'b1;
    done_in = 1'b0;
    @(negedge clk);
    // START
    check({tag, "_start_sel"}, 32'(sel_bus), 32'(v.exp_sel));
    check({tag, "_start_grant"}, grant, exp_g);
    check({tag, "_start_pulse"}, 32'(start_out), 32'd1);
    act_cnt += int'(active);
    // Request changes outside IDLE must be ignored
    req_bus = ~v.req;
    done_in = 1'b1;  // ignored in START
    @(negedge clk);
    for (int w = 0; w < waits; w++) begin
      check({tag, "_wait_pulse"}, 32'(start_out), 32'd0);
      check({tag, "_wait_tmo"}, 32'(timeout_err), 32'd0);
      check({tag, "_wait_grant"}, grant, exp_g);
      act_cnt += int'(active);
      done_in = (w == v.done_at);
      @(negedge clk);
    end
    // RELEASE
    check({tag, "_rel_tmo"}, 32'(timeout_err), 32'(v.exp_tmo));
    check({tag, "_rel_grant"}, grant, exp_g);
    act_cnt += int'(active);
    done_in = 1'b0;
    req_bus = '0;
    @(negedge clk);
    // IDLE
    act_cnt += int'(active);
    check({tag, "_idle_grant"}, grant, 32'd0);
    check({tag, "_idle_sel_hold"}, 32'(sel_bus), 32'(v.exp_sel));
    check({tag, "_idle_tmo"}, 32'(timeout_err), 32'd0);
    check({tag, "_active_cycles"}, 32'(act_cnt), 32'(v.exp_active));
  endtask

  initial begin
    int starts;
    int last_start;
    int cyc;

    //            req            done_at sel   tmo   active
    vecs[0] = '{32'h0000_0020, 3,  5'd5,  1'b0, 6};
    vecs[1] = '{32'h0000_0021, 0,  5'd0,  1'b0, 3};
    vecs[2] = '{32'h0000_0021, 0,  5'd5,  1'b0, 3};
    vecs[3] = '{32'h4000_0000, 0,  5'd30, 1'b0, 3};
    vecs[4] = '{32'h8000_0001, 0,  5'd31, 1'b0, 3};
    vecs[5] = '{32'h8000_0001, 0,  5'd0,  1'b0, 3};
    vecs[6] = '{32'h8000_0001, 1,  5'd31, 1'b0, 4};
    vecs[7] = '{32'h0000_0004, 99, 5'd2,  1'b1, 10};
    vecs[8] = '{32'h0000_0004, 7,  5'd2,  1'b0, 10};
    vecs[9] = '{32'h0000_0006, 0,  5'd1,  1'b0, 3};

    // Reset state and arbitration at the first edge after release
    #3;
    check("rst_sel", 32'(sel_bus), 32'd0);
    check("rst_grant", grant, 32'd0);
    check("rst_outs", {29'd0, start_out, active, timeout_err}, 32'd0);
    req_bus = 32'h1;
    enable  = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rel_grant", grant, 32'h1);
    check("rel_start", 32'(start_out), 32'd1);
    req_bus = '0;
    done_in = 1'b1;
    @(negedge clk);  // WAIT
    @(negedge clk);  // RELEASE
    done_in = 1'b0;
    @(negedge clk);  // IDLE
    check("rel_done_grant", grant, 32'd0);

    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

    // enable dropped during WAIT: transfer completes, no new grant follows
    req_bus = 32'h10;
    enable  = 1'b1;
    @(negedge clk);  // START
    @(negedge clk);  // WAIT
    enable = 1'b0;
    @(negedge clk);  // WAIT
    done_in = 1'b1;
    @(negedge clk);  // RELEASE
    done_in = 1'b0;
    check("en_rel_grant", grant, 32'h10);
    check("en_rel_active", 32'(active), 32'd1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("en_hold", {30'd0, active, start_out}, 32'd0);
    end

    // Reset during WAIT aborts at once; next search starts from bus 0
    req_bus = 32'h100;
    enable  = 1'b1;
    @(negedge clk);  // START, bus 8
    check("rm_sel8", 32'(sel_bus), 32'd8);
    req_bus = 32'h300;
    @(negedge clk);  // WAIT
    rst = 1'b0;
    #1;
    check("rm_grant", grant, 32'd0);
    check("rm_outs", {29'd0, start_out, active, timeout_err}, 32'd0);
    check("rm_sel", 32'(sel_bus), 32'd0);
    @(negedge clk);
    check("rm_no_pulse", {30'd0, start_out, timeout_err}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("rm_restart_sel", 32'(sel_bus), 32'd8);
    check("rm_restart_grant", grant, 32'h100);
    enable  = 1'b0;
    req_bus = '0;
    done_in = 1'b1;
    @(negedge clk);
    @(negedge clk);
    done_in = 1'b0;
    @(negedge clk);

    // Fairness: all requests, done tied high
    do_reset();
    req_bus    = 32'hFFFF_FFFF;
    done_in    = 1'b1;
    enable     = 1'b1;
    starts     = 0;
    last_start = 0;
    cyc        = 0;
    while (starts < 34 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if ($countones(grant) > 1) check("fair_onehot", grant, 32'd1 << sel_bus);
      if (start_out) begin
        check("fair_sel", 32'(sel_bus), 32'(starts % 32));
        if (starts > 0) check("fair_period", 32'(cyc - last_start), 32'd4);
        last_start = cyc;
        starts++;
      end
    end
    check("fair_starts", 32'(starts), 32'd34);
    enable  = 1'b0;
    req_bus = '0;
    done_in = 1'b0;
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
